// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// This package holds the arbiter state encoding, the default bus widths and the
// wait-counter width helper. The top, the timer and anyone else decoding arbiter
// state import it.
package mem_bus_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 255;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    // The counter must be able to hold TIMEOUT itself, because it saturates there.
    function automatic int timer_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_timer.sv
// mem_bus_arbiter_timer
// This is the wait-cycle counter for the arbiter. It counts upward while enabled
// and stops at TIMEOUT; it never wraps. A clear resets it to zero, a load presets
// it, and the counter flags expiry once it sits at TIMEOUT.
module mem_bus_arbiter_timer
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int CW = timer_width(TIMEOUT)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_value,
    input  logic          i_count_en,
    output logic          o_expired
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // Count when enabled and hold at the limit. A preset above the limit is clamped.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            count <= '0;
        end else if (i_load) begin
            count <= (i_load_value > LIMIT) ? LIMIT : i_load_value;
        end else if (i_count_en && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign o_expired = (count == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// This module shares one memory bus between the fetch port and the data port.
// It runs one transaction at a time. Each transaction ends when the memory
// signals ready or when the watchdog expires.
// Define MEM_ARB_RR_EN for round-robin arbitration between the two ports.
// By default the data port always has priority over the fetch port.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic                  i_ins_req,
    input  logic [ADDR_WIDTH-1:0] i_ins_addr,
    output logic                  o_ins_gnt,
    output logic                  o_ins_ack,
    output logic                  o_ins_err,
    output logic [DATA_WIDTH-1:0] o_ins_rdata,

    input  logic                  i_dat_req,
    input  logic                  i_dat_we,
    input  logic [ADDR_WIDTH-1:0] i_dat_addr,
    input  logic [DATA_WIDTH-1:0] i_dat_wdata,
    output logic                  o_dat_gnt,
    output logic                  o_dat_ack,
    output logic                  o_dat_err,
    output logic [DATA_WIDTH-1:0] o_dat_rdata,

    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_ready
);

    localparam int CW = timer_width(TIMEOUT);

    arb_state_t state;
    arb_state_t next_state;

    logic pick_dat;
    logic start_txn;
    logic finish_ok;
    logic finish_to;
    logic finish_any;
    logic busy;
    logic timer_expired;

`ifdef MEM_ARB_RR_EN
    logic favor_data;

    // Remember the last winner, so that on a tie the port that lost last time wins next.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            favor_data <= 1'b1;
        end else if (o_dat_gnt) begin
            favor_data <= 1'b0;
        end else if (o_ins_gnt) begin
            favor_data <= 1'b1;
        end
    end

    assign pick_dat = i_dat_req && (!i_ins_req || favor_data);
`else
    assign pick_dat = i_dat_req;
`endif

    assign start_txn  = o_ins_gnt | o_dat_gnt;
    assign finish_any = finish_ok | finish_to;
    assign busy       = (state != ARB_IDLE);

    mem_bus_arbiter_timer #(
        .TIMEOUT      (TIMEOUT)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (finish_any),
        .i_load       (start_txn),
        .i_load_value ({CW{1'b0}}),
        .i_count_en   (busy),
        .o_expired    (timer_expired)
    );

    // State register. A reset drops any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // In IDLE, grant one port combinationally. In BUSY, wait for ready or expiry;
    // if both happen in the same cycle, ready takes precedence.
    always_comb begin
        next_state = state;
        o_ins_gnt  = 1'b0;
        o_dat_gnt  = 1'b0;
        finish_ok  = 1'b0;
        finish_to  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (!i_rst) begin
                    if (pick_dat) begin
                        o_dat_gnt  = 1'b1;
                        next_state = ARB_BUSY_D;
                    end else if (i_ins_req) begin
                        o_ins_gnt  = 1'b1;
                        next_state = ARB_BUSY_I;
                    end
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (i_mem_ready) begin
                    finish_ok  = 1'b1;
                    next_state = ARB_IDLE;
                end else if (timer_expired) begin
                    finish_to  = 1'b1;
                    next_state = ARB_IDLE;
                end
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

    // Capture the winner's request onto the bus and hold it until the transaction ends.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else if (o_dat_gnt) begin
            o_mem_req   <= 1'b1;
            o_mem_we    <= i_dat_we;
            o_mem_addr  <= i_dat_addr;
            o_mem_wdata <= i_dat_wdata;
        end else if (o_ins_gnt) begin
            o_mem_req   <= 1'b1;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= i_ins_addr;
            o_mem_wdata <= '0;
        end else if (finish_any) begin
            o_mem_req   <= 1'b0;
        end
    end

    // Fetch completion: pulse ack for one cycle and return the word (zero on a timeout).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ins_ack   <= 1'b0;
            o_ins_err   <= 1'b0;
            o_ins_rdata <= '0;
        end else begin
            o_ins_ack <= 1'b0;
            o_ins_err <= 1'b0;
            if (finish_any && (state == ARB_BUSY_I)) begin
                o_ins_ack   <= 1'b1;
                o_ins_err   <= finish_to;
                o_ins_rdata <= finish_ok ? i_mem_rdata : '0;
            end
        end
    end

    // Data completion: same behaviour as fetch completion. Stores also receive an ack.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dat_ack   <= 1'b0;
            o_dat_err   <= 1'b0;
            o_dat_rdata <= '0;
        end else begin
            o_dat_ack <= 1'b0;
            o_dat_err <= 1'b0;
            if (finish_any && (state == ARB_BUSY_D)) begin
                o_dat_ack   <= 1'b1;
                o_dat_err   <= finish_to;
                o_dat_rdata <= finish_ok ? i_mem_rdata : '0;
            end
        end
    end

endmodule
